dct_block_scheduler: RTL and testbench

- Round-robin scheduler that shares one DCT_2D instance between NUM_REQ block producers (e.g. Y, Cb, Cr block buffers).
- Accepts one 8x8 pixel block at a time through a valid/ready handshake.
- Holds the block stable on the DCT input, pulses dct_enable once, and waits a fixed DCT latency.
- Captures the coefficients and presents them downstream (towards quantisation) with the source tag, using a valid/ready handshake.

---
 rtl/dct_block_scheduler.sv | 147 ++++++++++++++
 tb/tb_dct_block_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler
// Shares one DCT_2D engine between NUM_REQ block producers. Blocks are
// granted round-robin, held on the DCT input, and the coefficients are
// captured after a fixed latency and handed downstream with the source tag.
module dct_block_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int TAG_W       = 2,
    parameter int DCT_LATENCY = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*512-1:0] req_data,
    output logic                   dct_enable,
    output logic [511:0]           dct_pix,
    input  logic [511:0]           dct_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [511:0]           out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy,
    output logic [15:0]            block_count
);

    localparam int CNT_W = $clog2(DCT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DCT_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [511:0]       dctPix_q, dctPix_d;
    logic [511:0]       outData_q, outData_d;
    logic [TAG_W-1:0]   outTag_q, outTag_d;
    logic               outValid_q, outValid_d;
    logic [15:0]        blockCount_q, blockCount_d;

    logic               grantFound;
    logic [TAG_W-1:0]   grantIdx;
    logic [TAG_W-1:0]   nextPtr;
    logic [511:0]       grantData;
    logic [NUM_REQ-1:0] shiftedValid;
    int                 cand;

    // Round-robin search: the lowest offset from rrPtr_q with a valid request
    // wins, so the loop walks offsets downwards and lets later hits override.
    always_comb begin
        grantFound   = 1'b0;
        grantIdx     = '0;
        cand         = 0;
        shiftedValid = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand         = (int'(rrPtr_q) + off) % NUM_REQ;
            shiftedValid = req_valid >> cand;
            if (shiftedValid[0]) begin
                grantFound = 1'b1;
                grantIdx   = TAG_W'(cand);
            end
        end
        nextPtr   = TAG_W'((int'(grantIdx) + 1) % NUM_REQ);
        grantData = 512'(req_data >> (int'(grantIdx) * 512));
    end

    // Next-state logic: accept in IDLE, fire the DCT in START, count down the
    // engine latency in WAIT, then hold the result in OUT until it is taken.
    always_comb begin
        state_d      = state_q;
        rrPtr_d      = rrPtr_q;
        cnt_d        = cnt_q;
        dctPix_d     = dctPix_q;
        outData_d    = outData_q;
        outTag_d     = outTag_q;
        outValid_d   = outValid_q;
        blockCount_d = blockCount_q;
        case (state_q)
            IDLE: begin
                if (grantFound) begin
                    dctPix_d = grantData;
                    outTag_d = grantIdx;
                    rrPtr_d  = nextPtr;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    outData_d    = dct_out;
                    outValid_d   = 1'b1;
                    blockCount_d = blockCount_q + 16'd1;
                    state_d      = OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rrPtr_q      <= '0;
            cnt_q        <= '0;
            dctPix_q     <= '0;
            outData_q    <= '0;
            outTag_q     <= '0;
            outValid_q   <= 1'b0;
            blockCount_q <= '0;
        end else begin
            state_q      <= state_d;
            rrPtr_q      <= rrPtr_d;
            cnt_q        <= cnt_d;
            dctPix_q     <= dctPix_d;
            outData_q    <= outData_d;
            outTag_q     <= outTag_d;
            outValid_q   <= outValid_d;
            blockCount_q <= blockCount_d;
        end
    end

    assign req_ready   = (state_q == IDLE && grantFound) ? (NUM_REQ'(1) << grantIdx) : '0;
    assign dct_enable  = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign dct_pix     = dctPix_q;
    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_tag     = outTag_q;
    assign block_count = blockCount_q;

endmodule

// File: tb/tb_dct_block_scheduler.sv
// tb_dct_block_scheduler
// Directed phases with randomized data, checked every cycle against a
// transaction-level model of the scheduler and a stand-in DCT_2D engine.
module tb_dct_block_scheduler;

    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 2;
    localparam int LAT     = 20;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     reqValid;
    logic [NUM_REQ-1:0]     reqReady;
    logic [NUM_REQ*512-1:0] reqData;
    logic                   dctEnable;
    logic [511:0]           dctPix;
    logic [511:0]           dctOut;
    logic                   outValid;
    logic                   outReady;
    logic [511:0]           outData;
    logic [TAG_W-1:0]       outTag;
    logic                   busy;
    logic [15:0]            blockCount;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    nowCyc = 0;
    string phase  = "init";

    // Model of the scheduler: one block in flight, timed from its accept cycle.
    bit               mInFlight   = 1'b0;
    bit               mOutPending = 1'b0;
    int               mAccept     = 0;
    logic [TAG_W-1:0] mRr         = '0;
    logic [TAG_W-1:0] mTag        = '0;
    logic [511:0]     mPix        = '0;
    logic [511:0]     mData       = '0;
    logic [15:0]      mCount      = '0;

    dct_block_scheduler #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DCT_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady), .req_data(reqData),
        .dct_enable(dctEnable), .dct_pix(dctPix), .dct_out(dctOut),
        .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .out_tag(outTag),
        .busy(busy), .block_count(blockCount)
    );

    always #5 clock = ~clock;

    // Cycle index: cycle n runs between rising edges n and n+1.
    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in DCT engine whose output changes every cycle, so only a capture
    // in exactly the right cycle gives the expected coefficients.
    always @(negedge clock) dctOut <= fakeDct(dctPix, cyc);

    function automatic logic [511:0] fakeDct(input logic [511:0] pix, input int c);
        logic [511:0] r;
        int sum;
        sum = 0;
        r   = '0;
        for (int k = 0; k < 64; k++) begin
            sum = sum + int'(pix[k*8 +: 8]);
            r[k*8 +: 8] = pix[k*8 +: 8] + 8'(k) + 8'(c);
        end
        r[7:0] = 8'(sum / 64 + c);
        return r;
    endfunction

    function automatic int modelGrant(input logic [NUM_REQ-1:0] v, input int rr);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (v[(rr + off) % NUM_REQ]) return (rr + off) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NUM_REQ*512-1:0] randReqData();
        logic [NUM_REQ*512-1:0] r;
        for (int i = 0; i < NUM_REQ; i++) r[i*512 +: 512] = randBlock();
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int g;
        logic [NUM_REQ-1:0] expReady;
        g = modelGrant(reqValid, int'(mRr));
        expReady = (!mInFlight && g >= 0) ? (NUM_REQ'(1) << g) : '0;
        checkVal("req_ready", 512'(reqReady), 512'(expReady));
        checkVal("dct_enable", 512'(dctEnable),
                 512'(mInFlight && !mOutPending && nowCyc == mAccept + 1));
        checkVal("busy", 512'(busy), 512'(mInFlight));
        checkVal("out_valid", 512'(outValid), 512'(mOutPending));
        checkVal("dct_pix", dctPix, mPix);
        checkVal("out_data", outData, mData);
        checkVal("out_tag", 512'(outTag), 512'(mTag));
        checkVal("block_count", 512'(blockCount), 512'(mCount));
    endtask

    // Advance the model across the rising edge that ends cycle nowCyc.
    task automatic modelEdge();
        int g;
        if (reset) begin
            mInFlight = 1'b0; mOutPending = 1'b0; mRr = '0; mTag = '0;
            mPix = '0; mData = '0; mCount = '0;
        end else if (!mInFlight) begin
            g = modelGrant(reqValid, int'(mRr));
            if (g >= 0) begin
                mInFlight = 1'b1;
                mAccept   = nowCyc;
                mPix      = reqData[g*512 +: 512];
                mTag      = TAG_W'(g);
                mRr       = TAG_W'((g + 1) % NUM_REQ);
            end
        end else if (!mOutPending) begin
            if (nowCyc == mAccept + 1 + LAT) begin
                mData       = fakeDct(mPix, nowCyc);
                mOutPending = 1'b1;
                mCount      = mCount + 16'd1;
            end
        end else if (outReady) begin
            mInFlight   = 1'b0;
            mOutPending = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*512-1:0] d,
                                 input logic rdy, input logic rst);
        reqValid = v;
        reqData  = d;
        outReady = rdy;
        reset    = rst;
    endtask

    // Inputs are driven just after an edge; outputs are checked mid-cycle.
    task automatic runCycle();
        #2;
        nowCyc = cyc;
        if (!reset) checkOutput();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    initial begin
        int n;
        applyStimulus('0, '0, 1'b0, 1'b1);

        phase = "reset_idle";
        repeat (2) runCycle();
        for (int i = 0; i < 50; i++) begin
            applyStimulus('0, randReqData(), 1'($urandom), 1'b0);
            runCycle();
        end

        phase = "single";
        applyStimulus(3'b010, {(NUM_REQ*64){8'h80}}, 1'b1, 1'b0);
        n = 0;
        while (!mInFlight && n < 5) begin runCycle(); n++; end
        checkVal("single_busy", 512'(busy), 512'(1'b1));
        applyStimulus('0, {(NUM_REQ*64){8'h80}}, 1'b1, 1'b0);
        repeat (30) runCycle();
        checkVal("single_count", 512'(blockCount), 512'(16'd1));
        checkVal("single_tag", 512'(outTag), 512'(2'd1));

        phase = "round_robin";
        applyStimulus('0, '0, 1'b1, 1'b1);
        runCycle();
        for (int i = 0; i < 6 * (LAT + 3); i++) begin
            applyStimulus(3'b111, randReqData(), 1'b1, 1'b0);
            runCycle();
        end
        checkVal("rr_count", 512'(blockCount), 512'(16'd6));

        phase = "backpressure";
        n = 0;
        while (!mOutPending && n < 60) begin
            applyStimulus(3'b111, randReqData(), 1'b0, 1'b0);
            runCycle();
            n++;
        end
        checkVal("bp_valid", 512'(outValid), 512'(1'b1));
        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'b111, randReqData(), 1'b0, 1'b0);
            runCycle();
        end
        for (int i = 0; i < 30; i++) begin
            applyStimulus(3'b111, randReqData(), 1'b1, 1'b0);
            runCycle();
        end

        phase = "reset_wait";
        applyStimulus('0, randReqData(), 1'b1, 1'b0);
        repeat (LAT + 3) runCycle();
        n = 0;
        while (!mInFlight && n < 5) begin
            applyStimulus(3'b010, randReqData(), 1'b1, 1'b0);
            runCycle();
            n++;
        end
        applyStimulus('0, randReqData(), 1'b1, 1'b0);
        repeat (5) runCycle();
        applyStimulus('0, randReqData(), 1'b1, 1'b1);
        runCycle();
        applyStimulus(3'b111, randReqData(), 1'b1, 1'b0);
        runCycle();
        checkVal("rst_grant0", 512'(outTag), 512'(2'd0));
        applyStimulus('0, randReqData(), 1'b1, 1'b0);
        repeat (LAT + 3) runCycle();
        n = 0;
        while (!mInFlight && n < 5) begin
            applyStimulus(3'b100, randReqData(), 1'b1, 1'b0);
            runCycle();
            n++;
        end
        applyStimulus('0, randReqData(), 1'b1, 1'b0);
        repeat (LAT + 3) runCycle();
        checkVal("rst_tag2", 512'(outTag), 512'(2'd2));

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(NUM_REQ'($urandom_range(0, 7)), randReqData(),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) == 0));
            runCycle();
        end

        phase = "wrap";
        applyStimulus('0, randReqData(), 1'b1, 1'b0);
        repeat (LAT + 10) runCycle();
        force dut.blockCount_q = 16'hFFFE;
        #1;
        release dut.blockCount_q;
        mCount = 16'hFFFE;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(3'b001, randReqData(), 1'b1, 1'b0);
            runCycle();
        end
        checkVal("wrap_count", 512'(blockCount), 512'(16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
